// File: rtl/fifo_word_serializer_if.sv
// Bus bundle between the FIFO read port, the word serializer and the byte-wide sink.
// master = serializer side, slave = FIFO/sink side.
interface fifo_word_serializer_if;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_rd;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_word_serializer.sv
// Pops 32-bit words from the FIFO and streams them as valid/ready byte frames.
// Define FIFO_SER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module fifo_word_serializer #(
  parameter int unsigned LSB_FIRST = 1,
  parameter int          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_word_serializer_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_count
);

`ifdef FIFO_SER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, SEND = 2'd2, CHK = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, SEND = 2'd2} state_e;
`endif

  // The byte on the wire always sits at the outgoing end of the shift register.
  function automatic logic [7:0] cur_byte(input logic [31:0] w);
    return (LSB_FIRST != 0) ? w[7:0] : w[31:24];
  endfunction

  function automatic logic [31:0] shift_out(input logic [31:0] w);
    return (LSB_FIRST != 0) ? {8'h00, w[31:8]} : {w[23:0], 8'h00};
  endfunction

`ifdef FIFO_SER_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction
`endif

  state_e           state_q, state_d;
  logic [31:0]      sr_q, sr_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef FIFO_SER_CHECKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  logic       rd;
  logic       valid;
  logic       last;
  logic [7:0] data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
`ifdef FIFO_SER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef FIFO_SER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef FIFO_SER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    rd      = 1'b0;
    valid   = 1'b0;
    last    = 1'b0;
    data    = 8'h00;

    case (state_q)
      IDLE: begin
        // fifo_empty is only looked at here; later changes cannot disturb a word in flight.
        rd = !bus.fifo_empty && !rst;
        if (rd) state_d = WAIT;
      end

      WAIT: begin
        sr_d    = bus.fifo_data;
        idx_d   = 2'd0;
`ifdef FIFO_SER_CHECKSUM_EN
        chk_d   = xor_bytes(bus.fifo_data);
`endif
        state_d = SEND;
      end

      SEND: begin
        valid = 1'b1;
        data  = cur_byte(sr_q);
`ifndef FIFO_SER_CHECKSUM_EN
        last  = (idx_q == 2'd3);
`endif
        if (bus.m_ready) begin
          sr_d  = shift_out(sr_q);
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
`ifdef FIFO_SER_CHECKSUM_EN
            state_d = CHK;
`else
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
`endif
          end
        end
      end

`ifdef FIFO_SER_CHECKSUM_EN
      CHK: begin
        valid = 1'b1;
        data  = chk_q;
        last  = 1'b1;
        if (bus.m_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  assign bus.fifo_rd = rd;
  assign bus.m_valid = valid;
  assign bus.m_data  = data;
  assign bus.m_last  = last;
  assign busy        = (state_q != IDLE);
  assign word_count  = cnt_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Randomized bench: two serializers (LSB-first/4-bit count, MSB-first/16-bit count) share
// one FIFO model and sink, and are checked against a byte-queue reference model.
module tb_fifo_word_serializer;
`ifdef FIFO_SER_CHECKSUM_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_word_serializer_if ifa ();
  fifo_word_serializer_if ifb ();

  logic        busy_a, busy_b;
  logic [3:0]  wc_a;
  logic [15:0] wc_b;

  fifo_word_serializer #(.LSB_FIRST(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.master), .busy(busy_a), .word_count(wc_a)
  );

  fifo_word_serializer #(.LSB_FIRST(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.master), .busy(busy_b), .word_count(wc_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  int          left = 0;        // bytes of the current frame still to be accepted
  int          lat = 0;         // cycles until the first byte of a popped word appears
  int          words_done = 0;
  logic [31:0] next_data = 32'h0;
  bit          ready_rand = 1'b0;
  int          stall_left = -1;
  int          stall_n = 0;
  bit          after_rst = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  // One clock cycle: drive inputs, check outputs, advance the reference model.
  task automatic cycle();
    bit          rdy, exp_rd, exp_v, exp_last;
    logic [31:0] w;
    rdy = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (stall_n > 0 && left == stall_left && lat == 0) begin
      rdy = 1'b0;
      stall_n--;
    end
    ifa.m_ready    = rdy;
    ifb.m_ready    = rdy;
    ifa.fifo_empty = (fifo_q.size() == 0);
    ifb.fifo_empty = (fifo_q.size() == 0);
    ifa.fifo_data  = next_data;
    ifb.fifo_data  = next_data;
    #1;
    exp_rd   = (left == 0) && (fifo_q.size() != 0) && !rst;
    exp_v    = (left > 0) && (lat == 0);
    exp_last = exp_v && (left == 1);
    check_val("A.fifo_rd", ifa.fifo_rd, exp_rd);
    check_val("B.fifo_rd", ifb.fifo_rd, exp_rd);
    check_val("A.m_valid", ifa.m_valid, exp_v);
    check_val("B.m_valid", ifb.m_valid, exp_v);
    check_val("A.m_last", ifa.m_last, exp_last);
    check_val("B.m_last", ifb.m_last, exp_last);
    check_val("A.busy", busy_a, (left > 0));
    check_val("B.busy", busy_b, (left > 0));
    check_val("A.word_count", wc_a, words_done % 16);
    check_val("B.word_count", wc_b, words_done % 65536);
    if (exp_v) begin
      check_val("A.m_data", ifa.m_data, exp_a[0]);
      check_val("B.m_data", ifb.m_data, exp_b[0]);
    end
    if (after_rst) begin
      check_val("A.m_data_rst", ifa.m_data, 0);
      check_val("B.m_data_rst", ifb.m_data, 0);
    end
    next_data = $urandom;
    if (rst) begin
      left = 0;
      lat  = 0;
      exp_a.delete();
      exp_b.delete();
      words_done = 0;
    end else if (exp_rd) begin
      w = fifo_q.pop_front();
      next_data = w;
      for (int i = 0; i < 4; i++) begin
        exp_a.push_back(8'(w >> (8 * i)));
        exp_b.push_back(8'(w >> (8 * (3 - i))));
      end
      if (FRAME == 5) begin
        exp_a.push_back(xor4(w));
        exp_b.push_back(xor4(w));
      end
      left = FRAME;
      lat  = 1;
    end else if (lat > 0) begin
      lat--;
    end else if (exp_v && rdy) begin
      void'(exp_a.pop_front());
      void'(exp_b.pop_front());
      left--;
      if (left == 0) words_done++;
    end
    after_rst = rst;
    @(negedge clk);
  endtask

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while ((fifo_q.size() > 0 || left > 0) && n < maxc) begin
      cycle();
      n++;
    end
    check_val("drain", fifo_q.size() + left, 0);
  endtask

  initial begin
    int n;
    ifa.m_ready = 1'b1;  ifb.m_ready = 1'b1;
    ifa.fifo_empty = 1'b1; ifb.fifo_empty = 1'b1;
    ifa.fifo_data = '0;  ifb.fifo_data = '0;
    rst = 1'b1;
    @(negedge clk);
    repeat (3) cycle();
    rst = 1'b0;

    // single word, sink always ready
    fifo_q.push_back(32'h11223344);
    run_idle(40);
    check_val("t1.A.count", wc_a, 1);
    check_val("t1.B.count", wc_b, 1);

    // sink stalls three cycles while byte 1 is presented
    stall_left = FRAME - 1;
    stall_n    = 3;
    fifo_q.push_back(32'h11223344);
    run_idle(40);
    check_val("t2.stall_used", stall_n, 0);

    // two queued words back to back
    fifo_q.push_back(32'hAABBCCDD);
    fifo_q.push_back(32'h01020304);
    run_idle(60);
    check_val("t3.B.count", wc_b, 4);

    // empty FIFO: nothing moves
    repeat (20) cycle();

    // reset after two bytes of a word
    fifo_q.push_back(32'hCAFEF00D);
    n = 0;
    while (!(left == FRAME - 2 && lat == 0) && n < 40) begin
      cycle();
      n++;
    end
    check_val("t5.reached", left, FRAME - 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (8) cycle();
    check_val("t5.B.count", wc_b, 0);
    check_val("t5.A.busy", busy_a, 0);

    // 17 words through a 4-bit counter
    for (int k = 1; k <= 17; k++) begin
      fifo_q.push_back($urandom);
      run_idle(40);
      check_val("t6.A.wrap", wc_a, k % 16);
    end
    check_val("t6.B.count", wc_b, 17);

    // random traffic with random backpressure
    ready_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) fifo_q.push_back($urandom);
      cycle();
    end
    run_idle(800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_word_serializer.md
# fifo_word_serializer

Downstream drain stage for the 16-deep, 32-bit FIFO controller. Pops one 32-bit word at a time using the FIFO's `read`/`empty` interface and emits the word as four bytes on a valid/ready byte stream feeding the byte-wide transmit path. Handles FIFO read latency, sink backpressure and per-word framing, and keeps a running count of transmitted words.

## Interface
- `LSB_FIRST`, 1, byte order: 1 sends bits [7:0] first, 0 sends bits [31:24] first
- `CNT_W`, 16, width of `word_count`
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_data`  in  32  FIFO `Out`, valid the cycle after `fifo_rd`
- `fifo_rd`  out  1  FIFO read strobe, one cycle per word
- `m_data`  out  8  output byte
- `m_valid`  out  1  `m_data` valid
- `m_ready`  in  1  sink accepts byte
- `m_last`  out  1  marks final byte of a word frame
- `busy`  out  1  word in flight (state ≠ IDLE)
- `word_count`  out  CNT_W  words fully transmitted, wraps modulo 2^CNT_W

## Operation
- States: IDLE, WAIT, SEND, CHK (CHK exists only with the macro).
- IDLE: `fifo_rd` = !fifo_empty && !rst (combinational). If `fifo_rd`=1, go to WAIT.
- WAIT: capture `fifo_data` into a 32-bit shift register, byte index ← 0, go to SEND. `fifo_rd`=0.
- SEND: `m_valid`=1, `m_data` = current byte per `LSB_FIRST`. On `m_valid && m_ready`: index+1. On acceptance of byte 3: if checksum is enabled, go to CHK; otherwise increment `word_count` and go to IDLE.
- `m_last`=1 only while the final byte of the frame is presented: byte 3 without the macro, the checksum byte with it.
- Handshake: once `m_valid` rises, it stays high and `m_data`/`m_last` stay stable until accepted. `m_ready` may toggle freely. A byte transfers only when `m_valid && m_ready` at a rising edge.
- `fifo_rd` is never asserted when `fifo_empty`=1, never in WAIT/SEND/CHK, and never during `rst`.
- Reset values: `m_valid`=0, `m_data`=0x00, `m_last`=0, `fifo_rd`=0, `busy`=0, `word_count`=0, state IDLE, shift register 0, index 0.
- Reset mid-word: the word in flight is discarded, not re-read. All outputs return to reset values in the cycle after the `rst` edge.
- `word_count` wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- `fifo_rd` high in cycle N → `fifo_data` captured at end of N+1 → `m_valid`=1 in cycle N+2.
- With `m_ready` held 1: 6 cycles per word (IDLE, WAIT, 4×SEND), or 7 with checksum. The next `fifo_rd` comes in the cycle after the last byte is accepted, provided `!fifo_empty`.
- `word_count` updates on the edge that accepts the final frame byte.
- Backpressure adds exactly one cycle per stalled cycle. There is no byte skid and no bubble beyond the stall.
- `fifo_empty` is sampled only in IDLE. Changes in other states are ignored.

## Configuration
- `FIFO_SER_CHECKSUM_EN` defined: after byte 3, state CHK presents one extra byte = XOR of the four data bytes, with `m_last`=1. `word_count` increments on its acceptance. Frame is 5 bytes.
- Not defined: CHK state and XOR logic are absent. Frame is 4 bytes, with `m_last` on byte 3.

## Test plan
- FIFO holds 0x11223344, `LSB_FIRST`=1, `m_ready`=1 → `fifo_rd` for one cycle. `m_valid` rises 2 cycles later. Bytes are 0x44, 0x33, 0x22, 0x11, with `m_last` on 0x11. `word_count`=1. With macro: 5th byte 0x44 carries `m_last`.
- Same word, `LSB_FIRST`=0, `m_ready` low for 3 cycles on byte 1 → sequence 0x11, 0x22 (held stable 3 cycles), 0x33, 0x44. No duplicated or dropped bytes.
- Two words 0xAABBCCDD, 0x01020304 queued, `m_ready`=1 → second `fifo_rd` in the cycle after 0xAA (or checksum) is accepted. 8 (or 10) bytes total. `word_count`=2.
- `fifo_empty`=1 for 20 cycles → `fifo_rd`=0, `m_valid`=0, `busy`=0 throughout.
- `rst` asserted after 2 bytes of 0xCAFEF00D → next cycle all outputs 0 and state IDLE. The remaining bytes are never sent. `word_count` unchanged at 0.
- `CNT_W`=4, 17 words streamed → `word_count` reads 15 after word 15, 0 after word 16, 1 after word 17.
